// File: rtl/lat_pkg.sv
// Latency measurement shared types and constants.
// Used by the latency tester and the statistics collector.
package lat_pkg;

  localparam int LAT_W = 16;
  localparam int STB_W = 12;

  localparam logic [LAT_W-1:0] LAT_TIMEOUT = 16'hffff;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT_FIN,
    S_CAPTURE,
    S_DISARM,
    S_GAP,
    S_DONE
  } lat_state_t;

endpackage

// File: rtl/lat_stats_collector_if.sv
// Arm/finish handshake between latency tester and collector.
// The collector is the master: it drives the arm request.
interface lat_stats_collector_if;
  import lat_pkg::*;

  logic             lt_armed;
  logic             lt_finished;
  logic [LAT_W-1:0] lt_lat;
  logic [STB_W-1:0] lt_stb;

  modport master (
    output lt_armed,
    input  lt_finished,
    input  lt_lat,
    input  lt_stb
  );

  modport slave (
    input  lt_armed,
    output lt_finished,
    output lt_lat,
    output lt_stb
  );

endinterface

// File: rtl/lat_minmax_acc.sv
// Latency sum/min/max and worst stabilisation accumulator.
// clr restarts a series, upd folds in one valid sample.
module lat_minmax_acc
  import lat_pkg::*;
#(
  parameter  int LOG2_SAMPLES = 3,
  localparam int SUM_W = LAT_W + LOG2_SAMPLES
) (
  input  logic             clk27,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             upd,
  input  logic [LAT_W-1:0] lat_in,
  input  logic [STB_W-1:0] stb_in,
  output logic [SUM_W-1:0] sum,
  output logic [LAT_W-1:0] lat_min,
  output logic [LAT_W-1:0] lat_max,
  output logic [STB_W-1:0] stb_max
);

  always_ff @(posedge clk27) begin
    if (!reset_n || clr) begin
      sum     <= '0;
      lat_min <= LAT_TIMEOUT;
      lat_max <= '0;
      stb_max <= '0;
    end else if (upd) begin
      sum <= sum + SUM_W'(lat_in);
      if (lat_in < lat_min) lat_min <= lat_in;
      if (lat_in > lat_max) lat_max <= lat_in;
      if (stb_in > stb_max) stb_max <= stb_in;
    end
  end

endmodule

// File: rtl/lat_stats_collector.sv
// Runs a series of latency measurements and keeps
// min/max/avg latency plus worst stabilisation time.
module lat_stats_collector
  import lat_pkg::*;
#(
  parameter int LOG2_SAMPLES = 3,
  parameter int REARM_GAP    = 2700,
  parameter int MAX_TIMEOUTS = 4
) (
  input  logic                    clk27,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    abort,
  lat_stats_collector_if.master   lt,
  output logic                    busy,
  output logic                    done,
  output logic                    failed,
  output logic [LOG2_SAMPLES:0]   sample_cnt,
  output logic [2:0]              timeout_cnt,
  output logic [LAT_W-1:0]        lat_min,
  output logic [LAT_W-1:0]        lat_max,
  output logic [LAT_W-1:0]        lat_avg,
  output logic [STB_W-1:0]        stb_max
);

  localparam int CW    = LOG2_SAMPLES + 1;
  localparam int SUM_W = LAT_W + LOG2_SAMPLES;
  localparam int GAP_W = $clog2(REARM_GAP + 1);

  localparam logic [CW-1:0]    N_SAMP  = CW'(2 ** LOG2_SAMPLES);
  localparam logic [2:0]       MAX_TO  = 3'(MAX_TIMEOUTS);
  localparam logic [GAP_W-1:0] GAP_END = GAP_W'(REARM_GAP - 1);

  lat_state_t       state;
  logic             armed_q;
  logic [GAP_W-1:0] gap_cnt;
  logic [LAT_W-1:0] lat_r;
  logic [STB_W-1:0] stb_r;
  logic [SUM_W-1:0] acc_sum;
  logic             acc_clr;
  logic             acc_upd;
  logic             is_to;

  assign lt.lt_armed = armed_q;
  assign is_to       = (lat_r == LAT_TIMEOUT);

  assign acc_clr = !abort && start &&
                   (state == S_IDLE || state == S_DONE);
  assign acc_upd = !abort && !is_to && (state == S_CAPTURE);

  lat_minmax_acc #(.LOG2_SAMPLES(LOG2_SAMPLES)) u_acc (
    .clk27   (clk27),
    .reset_n (reset_n),
    .clr     (acc_clr),
    .upd     (acc_upd),
    .lat_in  (lat_r),
    .stb_in  (stb_r),
    .sum     (acc_sum),
    .lat_min (lat_min),
    .lat_max (lat_max),
    .stb_max (stb_max)
  );

  always_ff @(posedge clk27) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      armed_q     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      failed      <= 1'b0;
      sample_cnt  <= '0;
      timeout_cnt <= '0;
      lat_avg     <= '0;
      lat_r       <= '0;
      stb_r       <= '0;
      gap_cnt     <= '0;
    end else if (abort) begin
      // statistics stay readable after a cancel
      state   <= S_IDLE;
      armed_q <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      failed  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            sample_cnt  <= '0;
            timeout_cnt <= '0;
            lat_avg     <= '0;
            done        <= 1'b0;
            failed      <= 1'b0;
            busy        <= 1'b1;
            state       <= S_ARM;
          end
        end
        S_ARM: begin
          armed_q <= 1'b1;
          state   <= S_WAIT_FIN;
        end
        S_WAIT_FIN: begin
          if (lt.lt_finished) begin
            lat_r <= lt.lt_lat;
            stb_r <= lt.lt_stb;
            state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (is_to) begin
            if (timeout_cnt != 3'd7)
              timeout_cnt <= timeout_cnt + 3'd1;
          end else begin
            sample_cnt <= sample_cnt + CW'(1);
          end
          state <= S_DISARM;
        end
        S_DISARM: begin
          armed_q <= 1'b0;
          if (!lt.lt_finished) begin
            gap_cnt <= '0;
            state   <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_END) begin
            if (sample_cnt == N_SAMP) begin
              done    <= 1'b1;
              busy    <= 1'b0;
              lat_avg <= LAT_W'(acc_sum >> LOG2_SAMPLES);
              state   <= S_DONE;
            end else if (timeout_cnt >= MAX_TO) begin
              failed  <= 1'b1;
              busy    <= 1'b0;
              lat_avg <= '0;
              state   <= S_DONE;
            end else begin
              state <= S_ARM;
            end
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lat_stats_collector.sv
// Directed series with randomised tester timing and sample order,
// checked against a per-run statistics model.
module tb_lat_stats_collector;
  import lat_pkg::*;

  localparam int L2  = 3;
  localparam int NS  = 8;
  localparam int GAP = 2700;
  localparam int MTO = 4;

  logic        clk27;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic        busy;
  logic        done;
  logic        failed;
  logic [L2:0] sample_cnt;
  logic [2:0]  timeout_cnt;
  logic [15:0] lat_min;
  logic [15:0] lat_max;
  logic [15:0] lat_avg;
  logic [11:0] stb_max;

  int errors;
  int checks;
  int arm_pulses;
  int arm_base;

  logic [15:0] q_lat[$];
  logic [11:0] q_stb[$];
  int          s_lat[$];
  int          s_stb[$];

  typedef struct {
    bit dn;
    bit fl;
    int scnt;
    int tcnt;
    int mn;
    int mx;
    int avg;
    int sb;
    int runs;
  } exp_t;

  exp_t e;

  lat_stats_collector_if lt();

  lat_stats_collector #(
    .LOG2_SAMPLES (L2),
    .REARM_GAP    (GAP),
    .MAX_TIMEOUTS (MTO)
  ) dut (
    .clk27       (clk27),
    .reset_n     (reset_n),
    .start       (start),
    .abort       (abort),
    .lt          (lt),
    .busy        (busy),
    .done        (done),
    .failed      (failed),
    .sample_cnt  (sample_cnt),
    .timeout_cnt (timeout_cnt),
    .lat_min     (lat_min),
    .lat_max     (lat_max),
    .lat_avg     (lat_avg),
    .stb_max     (stb_max)
  );

  initial clk27 = 1'b0;
  always #5 clk27 = ~clk27;

  // tester model: 0 idle, 1 measuring, 2 finished, 3 dropping
  initial begin
    int t_st;
    int cnt;
    logic armed_d;
    t_st = 0;
    cnt = 0;
    armed_d = 1'b0;
    arm_pulses = 0;
    lt.lt_finished = 1'b0;
    lt.lt_lat = '0;
    lt.lt_stb = '0;
    forever begin
      @(posedge clk27);
      #1;
      if (lt.lt_armed && !armed_d) arm_pulses++;
      armed_d = lt.lt_armed;
      case (t_st)
        0: if (lt.lt_armed) begin
          cnt = $urandom_range(0, 5);
          t_st = 1;
        end
        1: if (!lt.lt_armed) t_st = 0;
        else if (cnt > 0) cnt--;
        else begin
          if (q_lat.size() > 0) begin
            lt.lt_lat = q_lat.pop_front();
            lt.lt_stb = q_stb.pop_front();
          end else begin
            lt.lt_lat = 16'hffff;
            lt.lt_stb = '0;
          end
          lt.lt_finished = 1'b1;
          t_st = 2;
        end
        2: if (!lt.lt_armed) begin
          cnt = $urandom_range(0, 3);
          t_st = 3;
        end
        default: if (cnt > 0) cnt--;
        else begin
          lt.lt_finished = 1'b0;
          lt.lt_lat = 16'($urandom);
          lt.lt_stb = 12'($urandom);
          t_st = 0;
        end
      endcase
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk27);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // statistics of a series, run by run, from the returned values
  function automatic exp_t model();
    exp_t r;
    longint sum;
    r = '{default: 0};
    r.mn = 'hffff;
    sum = 0;
    for (int i = 0; i < s_lat.size(); i++) begin
      r.runs++;
      if (s_lat[i] == 'hffff) begin
        if (r.tcnt < 7) r.tcnt++;
      end else begin
        r.scnt++;
        sum += s_lat[i];
        if (s_lat[i] < r.mn) r.mn = s_lat[i];
        if (s_lat[i] > r.mx) r.mx = s_lat[i];
        if (s_stb[i] > r.sb) r.sb = s_stb[i];
      end
      if (r.scnt == NS) begin
        r.dn = 1'b1;
        break;
      end
      if (r.tcnt >= MTO) begin
        r.fl = 1'b1;
        break;
      end
    end
    r.avg = r.dn ? int'(sum / NS) : 0;
    return r;
  endfunction

  task automatic begin_series(input string tag);
    e = model();
    foreach (s_lat[i]) begin
      q_lat.push_back(16'(s_lat[i]));
      q_stb.push_back(12'(s_stb[i]));
    end
    arm_base = arm_pulses;
    pulse_start();
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_done_clr"}, 32'(done | failed), 32'd0);
  endtask

  task automatic clear_q();
    q_lat.delete();
    q_stb.delete();
    s_lat.delete();
    s_stb.delete();
  endtask

  task automatic finish_series(input string tag);
    int left;
    for (int i = 0; i < 40000; i++) begin
      step();
      if (done || failed) break;
    end
    chk({tag, "_ended"}, 32'(done | failed), 32'd1);
    chk({tag, "_done"}, 32'(done), 32'(e.dn));
    chk({tag, "_failed"}, 32'(failed), 32'(e.fl));
    chk({tag, "_scnt"}, 32'(sample_cnt), 32'(e.scnt));
    chk({tag, "_tcnt"}, 32'(timeout_cnt), 32'(e.tcnt));
    chk({tag, "_min"}, 32'(lat_min), 32'(e.mn));
    chk({tag, "_max"}, 32'(lat_max), 32'(e.mx));
    chk({tag, "_avg"}, 32'(lat_avg), 32'(e.avg));
    chk({tag, "_stb"}, 32'(stb_max), 32'(e.sb));
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_armed"}, 32'(lt.lt_armed), 32'd0);
    chk({tag, "_arms"}, 32'(arm_pulses - arm_base),
        32'(e.runs));
    left = s_lat.size() - e.runs;
    chk({tag, "_left"}, 32'(q_lat.size()), 32'(left));
    clear_q();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_failed"}, 32'(failed), 32'd0);
    chk({tag, "_scnt"}, 32'(sample_cnt), 32'd0);
    chk({tag, "_tcnt"}, 32'(timeout_cnt), 32'd0);
    chk({tag, "_min"}, 32'(lat_min), 32'hffff);
    chk({tag, "_max"}, 32'(lat_max), 32'd0);
    chk({tag, "_avg"}, 32'(lat_avg), 32'd0);
    chk({tag, "_stb"}, 32'(stb_max), 32'd0);
    chk({tag, "_armed"}, 32'(lt.lt_armed), 32'd0);
  endtask

  initial begin
    int n;
    int j;
    int tmp;
    errors = 0;
    checks = 0;
    reset_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    repeat (3) step();
    chk_reset("rst0");
    reset_n = 1'b1;
    step();

    // eight good runs in random order, rearm gap measured
    for (int i = 0; i < NS; i++) begin
      s_lat.push_back(100 + i);
      s_stb.push_back(5);
    end
    for (int i = NS - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      tmp = s_lat[i];
      s_lat[i] = s_lat[j];
      s_lat[j] = tmp;
    end
    begin_series("good");
    for (n = 0; n < 200; n++) begin
      @(posedge clk27);
      if (lt.lt_finished) break;
    end
    chk("gap_fin_rise", 32'(lt.lt_finished), 32'd1);
    for (n = 0; n < 200; n++) begin
      @(posedge clk27);
      if (!lt.lt_finished) break;
    end
    chk("gap_fin_fall", 32'(lt.lt_finished), 32'd0);
    n = 0;
    while (n < 5000) begin
      @(posedge clk27);
      n++;
      #1;
      if (lt.lt_armed) break;
    end
    chk("gap_len", 32'(n), 32'(GAP + 1));
    finish_series("good");

    // every run times out
    for (int i = 0; i < 6; i++) begin
      s_lat.push_back('hffff);
      s_stb.push_back(int'($urandom_range(0, 4095)));
    end
    begin_series("tmo");
    finish_series("tmo");

    // one timeout among good runs; start while busy ignored
    s_lat.push_back(200);
    s_stb.push_back(int'($urandom_range(0, 4095)));
    s_lat.push_back('hffff);
    s_stb.push_back(int'($urandom_range(0, 4095)));
    for (int i = 0; i < 7; i++) begin
      s_lat.push_back(200);
      s_stb.push_back(int'($urandom_range(0, 4095)));
    end
    begin_series("mix");
    repeat (int'($urandom_range(20, 400))) step();
    pulse_start();
    chk("busy_start_ign", 32'(busy), 32'd1);
    finish_series("mix");

    // abort beats start in WAIT_FIN
    s_lat.push_back(500);
    s_stb.push_back(7);
    begin_series("abt");
    for (n = 0; n < 50; n++) begin
      step();
      if (lt.lt_armed) break;
    end
    chk("abt_armed", 32'(lt.lt_armed), 32'd1);
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    chk("abt_busy", 32'(busy), 32'd0);
    chk("abt_armed0", 32'(lt.lt_armed), 32'd0);
    chk("abt_done", 32'(done | failed), 32'd0);
    chk("abt_min", 32'(lat_min), 32'hffff);
    repeat (20) step();
    chk("abt_stay_busy", 32'(busy), 32'd0);
    chk("abt_stay_arm", 32'(lt.lt_armed), 32'd0);
    clear_q();

    // reset during GAP, then a clean restart
    s_lat.push_back(300);
    s_stb.push_back(9);
    s_lat.push_back(301);
    s_stb.push_back(3);
    begin_series("rg");
    for (n = 0; n < 200; n++) begin
      @(posedge clk27);
      if (lt.lt_finished) break;
    end
    for (n = 0; n < 200; n++) begin
      @(posedge clk27);
      if (!lt.lt_finished) break;
    end
    repeat (5) step();
    chk("rg_pre_scnt", 32'(sample_cnt), 32'd1);
    chk("rg_pre_max", 32'(lat_max), 32'd300);
    reset_n = 1'b0;
    step();
    chk_reset("rg");
    reset_n = 1'b1;
    step();
    pulse_start();
    chk("rg_busy", 32'(busy), 32'd1);
    for (n = 0; n < 50; n++) begin
      step();
      if (lt.lt_armed) break;
    end
    chk("rg_rearm", 32'(lt.lt_armed), 32'd1);
    chk("rg_scnt", 32'(sample_cnt), 32'd0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    clear_q();
    repeat (10) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
